bc_link_ctrl: RTL and testbench

//  Serial link engine between the breadcrumb buffer FIFOs and the Avoidance unit.

---
 rtl/bc_link_ctrl.sv | 159 +++++++++++++++
 tb/tb_bc_link_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_link_ctrl.sv
// Serial link engine: pops words from the incoming FIFO, exchanges each with Avoidance
// over a mode-0 SPI-style frame (MSB first), and pushes the received word to the outgoing FIFO.
module bc_link_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              link_en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              rx_full,
  output logic              rx_wr_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              cs_n,
  output logic              to_avoid,
  input  logic              from_avoid,
  output logic              busy
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    DONE,
    WAIT_RX
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              fifo_rd_en_q, fifo_rd_en_d;
  logic              rx_wr_en_q, rx_wr_en_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              to_avoid_q, to_avoid_d;
  logic              busy_q, busy_d;
  logic              div_wrap;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    fifo_rd_en_d = 1'b0;
    rx_wr_en_d   = 1'b0;
    sck_d        = sck_q;
    cs_n_d       = cs_n_q;
    to_avoid_d   = to_avoid_q;
    div_wrap     = (div_cnt_q == CNT_W'(CLK_DIV - 1));

    unique case (state_q)
      IDLE: begin
        if (link_en && !fifo_empty && !rx_full) begin
          state_d      = FETCH;
          fifo_rd_en_d = 1'b1;
        end
      end
      FETCH: begin
        state_d = LOAD;
        cs_n_d  = 1'b0;
      end
      LOAD: begin
        state_d    = SHIFT;
        tx_shift_d = fifo_dout;
        to_avoid_d = fifo_dout[DATA_W-1];
        sck_d      = 1'b0;
        div_cnt_d  = '0;
        bit_cnt_d  = '0;
      end
      SHIFT: begin
        if (!div_wrap) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          sck_d     = !sck_q;
          if (!sck_q) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], from_avoid};
          end else begin
            tx_shift_d = tx_shift_q << 1;
            to_avoid_d = tx_shift_q[DATA_W-2];
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              // Outputs are registered, so the DONE-cycle write is decided here.
              state_d    = DONE;
              cs_n_d     = 1'b1;
              to_avoid_d = 1'b0;
              rx_data_d  = rx_shift_q;
              rx_wr_en_d = !rx_full;
            end
          end
        end
      end
      DONE: begin
        // A write already issued on entry means the word is delivered.
        state_d = rx_wr_en_q ? IDLE : WAIT_RX;
      end
      WAIT_RX: begin
        if (!rx_full) begin
          rx_wr_en_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      fifo_rd_en_q <= 1'b0;
      rx_wr_en_q   <= 1'b0;
      sck_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      to_avoid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      rx_wr_en_q   <= rx_wr_en_d;
      sck_q        <= sck_d;
      cs_n_q       <= cs_n_d;
      to_avoid_q   <= to_avoid_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_rd_en = fifo_rd_en_q;
  assign rx_wr_en   = rx_wr_en_q;
  assign rx_data    = rx_data_q;
  assign sck        = sck_q;
  assign cs_n       = cs_n_q;
  assign to_avoid   = to_avoid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bc_link_ctrl.sv
// Bench for bc_link_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) with a FIFO model,
// an Avoidance slave model and a frame monitor; expectations come from the link rules.
module tb_bc_link_ctrl;

  localparam int unsigned DIV0 = 2;
  localparam int unsigned DIV1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_en    [2];
  logic        fifo_empty [2];
  logic        fifo_rd_en [2];
  logic [15:0] fifo_dout  [2];
  logic        rx_full    [2];
  logic        rx_wr_en   [2];
  logic [15:0] rx_data    [2];
  logic        sck        [2];
  logic        cs_n       [2];
  logic        to_avoid   [2];
  logic        from_avoid [2];
  logic        busy       [2];

  always #5 clk = ~clk;

  bc_link_ctrl #(.DATA_W(16), .CLK_DIV(DIV0)) u_dut0 (
    .clk(clk), .rst(rst), .link_en(link_en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_rd_en(fifo_rd_en[0]), .fifo_dout(fifo_dout[0]), .rx_full(rx_full[0]),
    .rx_wr_en(rx_wr_en[0]), .rx_data(rx_data[0]), .sck(sck[0]), .cs_n(cs_n[0]),
    .to_avoid(to_avoid[0]), .from_avoid(from_avoid[0]), .busy(busy[0])
  );

  bc_link_ctrl #(.DATA_W(16), .CLK_DIV(DIV1)) u_dut1 (
    .clk(clk), .rst(rst), .link_en(link_en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_rd_en(fifo_rd_en[1]), .fifo_dout(fifo_dout[1]), .rx_full(rx_full[1]),
    .rx_wr_en(rx_wr_en[1]), .rx_data(rx_data[1]), .sck(sck[1]), .cs_n(cs_n[1]),
    .to_avoid(to_avoid[1]), .from_avoid(from_avoid[1]), .busy(busy[1])
  );

  // Incoming FIFO model: pushed by the stimulus, popped by the DUT.
  logic [15:0] fifo_mem [2][64];
  int unsigned wr_ptr [2] = '{0, 0};
  int unsigned rd_ptr [2] = '{0, 0};

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (fifo_rd_en[i]) begin
        fifo_dout[i] <= fifo_mem[i][rd_ptr[i] % 64];
        rd_ptr[i]    <= rd_ptr[i] + 1;
      end

  always_comb
    for (int i = 0; i < 2; i++) fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);

  // Avoidance slave and frame monitor, sampled on the falling clk edge.
  logic [15:0] miso_mem  [2][64];
  logic [15:0] mosi_log  [2][64];
  int unsigned edge_log  [2][64];
  int unsigned gap_log   [2][64];
  int unsigned start_log [2][64];
  logic [15:0] rx_log    [2][64];
  logic [15:0] cur_miso  [2];
  logic [15:0] cur_mosi  [2];
  int unsigned cur_edges [2] = '{0, 0};
  int unsigned bitpos    [2] = '{0, 0};
  int unsigned nst       [2] = '{0, 0};
  int unsigned nfr       [2] = '{0, 0};
  int unsigned nrx       [2] = '{0, 0};
  int unsigned nrd       [2] = '{0, 0};
  int unsigned rd_cyc    [2] = '{0, 0};
  int unsigned wr_cyc    [2] = '{0, 0};
  int unsigned cs_run    [2] = '{0, 0};
  int unsigned last_rise [2] = '{0, 0};
  int unsigned last_per  [2] = '{0, 0};
  int unsigned rise_bad  [2] = '{0, 0};
  int unsigned overlap   [2] = '{0, 0};
  logic        prev_cs   [2] = '{1'b1, 1'b1};
  logic        prev_sck  [2] = '{1'b0, 1'b0};
  int unsigned cyc = 0;

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] && !cs_n[i]) begin
        gap_log[i][nst[i] % 64]   = cs_run[i];
        start_log[i][nst[i] % 64] = cyc;
        cur_miso[i]   = miso_mem[i][nst[i] % 64];
        nst[i]++;
        bitpos[i]     = 15;
        from_avoid[i] = cur_miso[i][15];
        cur_edges[i]  = 0;
        cur_mosi[i]   = '0;
        cs_run[i]     = 0;
      end else if (cs_n[i]) begin
        cs_run[i]++;
      end
      if (!cs_n[i] && !prev_sck[i] && sck[i]) begin
        cur_mosi[i] = {cur_mosi[i][14:0], to_avoid[i]};
        if (cur_edges[i] > 0) begin
          last_per[i] = cyc - last_rise[i];
          if (last_per[i] != 2 * div_of(i)) rise_bad[i]++;
        end
        last_rise[i] = cyc;
        cur_edges[i]++;
      end
      if (!cs_n[i] && prev_sck[i] && !sck[i] && bitpos[i] > 0) begin
        bitpos[i]--;
        from_avoid[i] = cur_miso[i][bitpos[i]];
      end
      if (!prev_cs[i] && cs_n[i]) begin
        mosi_log[i][nfr[i] % 64] = cur_mosi[i];
        edge_log[i][nfr[i] % 64] = cur_edges[i];
        nfr[i]++;
      end
      if (rx_wr_en[i]) begin
        rx_log[i][nrx[i] % 64] = rx_data[i];
        wr_cyc[i] = cyc;
        nrx[i]++;
      end
      if (fifo_rd_en[i]) begin
        rd_cyc[i] = cyc;
        nrd[i]++;
      end
      if (fifo_rd_en[i] && rx_wr_en[i]) overlap[i]++;
      prev_cs[i]  = cs_n[i];
      prev_sck[i] = sck[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [15:0] w);
    fifo_mem[i][wr_ptr[i] % 64] = w;
    wr_ptr[i]++;
  endtask

  task automatic wait_rx(input int i, input int unsigned target, input int budget);
    int k = 0;
    while (nrx[i] < target && k < budget) begin
      step(1);
      k++;
    end
    check("wait_rx", nrx[i], target);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int k = 0;
    while (busy[i] !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    check("wait_idle", {31'd0, busy[i]}, 32'd0);
  endtask

  task automatic wait_cs(input int i, input logic level, input int budget);
    int k = 0;
    while (cs_n[i] !== level && k < budget) begin
      step(1);
      k++;
    end
    check("wait_cs", {31'd0, cs_n[i]}, {31'd0, level});
  endtask

  task automatic wait_edges(input int i, input int unsigned n, input int budget);
    int k = 0;
    while (!(cs_n[i] === 1'b0 && cur_edges[i] >= n) && k < budget) begin
      step(1);
      k++;
    end
    check("wait_edges", cur_edges[i], n);
  endtask

  int unsigned b_fr, b_rx, b_rd, b_st, viol;
  logic [15:0] tx6 [8];

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      link_en[i] = 1'b0;
      rx_full[i] = 1'b0;
      for (int k = 0; k < 64; k++) miso_mem[i][k] = 16'($urandom);
    end
    step(2);
    check("rst_outs0", {26'd0, fifo_rd_en[0], rx_wr_en[0], sck[0], cs_n[0], to_avoid[0], busy[0]}, 32'h4);
    check("rst_outs1", {26'd0, fifo_rd_en[1], rx_wr_en[1], sck[1], cs_n[1], to_avoid[1], busy[1]}, 32'h4);
    check("rst_rx_data", rx_data[0], 32'h0);
    rst = 1'b0;
    step(2);

    // Single frame: data both ways, write latency, single pulse, 16 sck edges.
    b_fr = nfr[0]; b_rx = nrx[0]; b_rd = nrd[0]; b_st = nst[0];
    miso_mem[0][nst[0]] = 16'h3C5A;
    push(0, 16'hA5C3);
    link_en[0] = 1'b1;
    wait_rx(0, b_rx + 1, 200);
    check("t1_wr_pulse", {31'd0, rx_wr_en[0]}, 32'd1);
    check("t1_rx_data", rx_data[0], 32'h3C5A);
    check("t1_latency", wr_cyc[0] - rd_cyc[0], (3 + 2 * 16 * DIV0) - 1);
    check("t1_mosi", mosi_log[0][b_fr], 32'hA5C3);
    check("t1_edges", edge_log[0][b_fr], 32'd16);
    step(1);
    check("t1_single_pulse", {31'd0, rx_wr_en[0]}, 32'd0);
    wait_idle(0, 20);
    check("t1_pops", nrd[0] - b_rd, 32'd1);

    // Back-to-back frames.
    b_fr = nfr[0]; b_rx = nrx[0]; b_rd = nrd[0]; b_st = nst[0];
    push(0, 16'h0001);
    push(0, 16'hFFFF);
    wait_rx(0, b_rx + 2, 400);
    check("t2_mosi0", mosi_log[0][b_fr], 32'h0001);
    check("t2_mosi1", mosi_log[0][b_fr + 1], 32'hFFFF);
    check("t2_rx0", rx_log[0][b_rx], miso_mem[0][b_st]);
    check("t2_rx1", rx_log[0][b_rx + 1], miso_mem[0][b_st + 1]);
    check("t2_cs_gap", gap_log[0][b_st + 1], 32'd3);
    check("t2_period", start_log[0][b_st + 1] - start_log[0][b_st], 2 * 16 * DIV0 + 4);
    step(20);
    check("t2_pops", nrd[0] - b_rd, 32'd2);
    check("t2_idle", {30'd0, busy[0], cs_n[0]}, 32'd1);
    check("t2_empty", {31'd0, fifo_empty[0]}, 32'd1);

    // Outgoing FIFO full at frame end.
    b_fr = nfr[0]; b_rx = nrx[0]; b_rd = nrd[0]; b_st = nst[0];
    miso_mem[0][nst[0]] = 16'h1234;
    push(0, 16'h5AA5);
    wait_cs(0, 1'b0, 20);
    rx_full[0] = 1'b1;
    push(0, 16'hC0DE);
    wait_cs(0, 1'b1, 200);
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      if (rx_wr_en[0] !== 1'b0 || fifo_rd_en[0] !== 1'b0 || busy[0] !== 1'b1) viol++;
      step(1);
    end
    check("t3_hold", viol, 32'd0);
    rx_full[0] = 1'b0;
    step(1);
    check("t3_wr_pulse", {31'd0, rx_wr_en[0]}, 32'd1);
    check("t3_rx_data", rx_data[0], 32'h1234);
    check("t3_no_pop", nrd[0] - b_rd, 32'd1);
    wait_rx(0, b_rx + 2, 200);
    check("t3_mosi0", mosi_log[0][b_fr], 32'h5AA5);
    check("t3_mosi1", mosi_log[0][b_fr + 1], 32'hC0DE);
    check("t3_rx1", rx_log[0][b_rx + 1], miso_mem[0][b_st + 1]);
    wait_idle(0, 20);

    // link_en low: nothing starts; dropped mid-frame: that frame completes only.
    link_en[0] = 1'b0;
    b_fr = nfr[0]; b_rx = nrx[0]; b_rd = nrd[0]; b_st = nst[0];
    push(0, 16'h0F0F);
    push(0, 16'hBEEF);
    step(50);
    check("t4_no_pop", nrd[0] - b_rd, 32'd0);
    check("t4_no_frame", nst[0] - b_st, 32'd0);
    check("t4_cs_high", {31'd0, cs_n[0]}, 32'd1);
    link_en[0] = 1'b1;
    wait_edges(0, 5, 100);
    link_en[0] = 1'b0;
    wait_rx(0, b_rx + 1, 200);
    check("t4_mosi", mosi_log[0][b_fr], 32'h0F0F);
    check("t4_rx", rx_log[0][b_rx], miso_mem[0][b_st]);
    step(60);
    check("t4_one_pop", nrd[0] - b_rd, 32'd1);
    check("t4_one_frame", nst[0] - b_st, 32'd1);
    check("t4_fifo_left", {31'd0, fifo_empty[0]}, 32'd0);

    // Reset mid-frame at bit 8.
    b_fr = nfr[0]; b_rx = nrx[0]; b_rd = nrd[0]; b_st = nst[0];
    link_en[0] = 1'b1;
    wait_edges(0, 8, 100);
    rst = 1'b1;
    #1;
    check("t5_rst_outs", {28'd0, cs_n[0], sck[0], to_avoid[0], busy[0]}, 32'h8);
    check("t5_rst_strobes", {30'd0, rx_wr_en[0], fifo_rd_en[0]}, 32'd0);
    check("t5_rst_rx_data", rx_data[0], 32'h0);
    step(2);
    rst = 1'b0;
    step(10);
    check("t5_no_write", nrx[0] - b_rx, 32'd0);
    check("t5_aborted", {31'd0, edge_log[0][b_fr] < 16}, 32'd1);
    check("t5_idle", {31'd0, busy[0]}, 32'd0);
    push(0, 16'h7E57);
    wait_rx(0, b_rx + 1, 200);
    check("t5_mosi", mosi_log[0][b_fr + 1], 32'h7E57);
    check("t5_edges", edge_log[0][b_fr + 1], 32'd16);
    check("t5_rx", rx_log[0][b_rx], miso_mem[0][b_st + 1]);
    wait_idle(0, 20);
    check("t_rise_period0", rise_bad[0], 32'd0);

    // CLK_DIV=1 instance: 8 random words in and out, in order.
    for (int k = 0; k < 8; k++) begin
      tx6[k] = 16'($urandom);
      push(1, tx6[k]);
    end
    link_en[1] = 1'b1;
    wait_rx(1, 8, 600);
    for (int k = 0; k < 8; k++) begin
      check("t6_mosi", mosi_log[1][k], tx6[k]);
      check("t6_rx", rx_log[1][k], miso_mem[1][k]);
      check("t6_edges", edge_log[1][k], 32'd16);
    end
    check("t6_sck_period", last_per[1], 32'd2);
    check("t6_rise_bad", rise_bad[1], 32'd0);
    check("t_no_overlap", overlap[0] + overlap[1], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
